controller: RTL and testbench

- Control unit of the single-cycle ARM-subset processor.
- Decodes Instr[31:12] into datapath control signals.
- Holds the NZCV condition-flag register and gates all architectural writes (register file, memory, PC) by the instruction's condition field.
- Sits between instruction memory and the datapath.

---
 rtl/arm_ctrl_pkg.sv | 51 +++++
 rtl/controller_condlogic.sv | 68 ++++++
 rtl/controller.sv | 123 ++++++++++++
 tb/tb_controller.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM-subset control unit: condition codes,
// instruction classes, ALU operations and immediate-extend selects.
package arm_ctrl_pkg;

  // Condition field encodings (Instr[31:28])
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // Data-processing cmd field (Funct[4:1]) values that the ALU supports
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Instruction class (Instr[27:26])
  typedef enum logic [1:0] {
    OP_DP   = 2'b00,
    OP_MEM  = 2'b01,
    OP_BR   = 2'b10,
    OP_NONE = 2'b11
  } op_e;

  // ALUControl encodings
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_e;

  // Extend-unit select
  typedef enum logic [1:0] {
    IMM_DP  = 2'b00,
    IMM_MEM = 2'b01,
    IMM_BR  = 2'b10
  } imm_src_e;

endpackage

// File: rtl/controller_condlogic.sv
// Condition logic: holds the NZCV flags, evaluates the condition field
// against them and gates every architectural write with the result.
module controller_condlogic
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite
);

  logic [3:0] r_flags;
  logic       w_n, w_z, w_c, w_v;
  logic       w_cond_ex;
  logic [1:0] w_flag_write;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Evaluate the condition field against the stored (previous-cycle) flags
  always_comb begin
    // NOTE: default first so every path assigns w_cond_ex and no latch is inferred.
    w_cond_ex = 1'b0;
    case (Cond)
      COND_EQ: w_cond_ex = w_z;
      COND_NE: w_cond_ex = ~w_z;
      COND_CS: w_cond_ex = w_c;
      COND_CC: w_cond_ex = ~w_c;
      COND_MI: w_cond_ex = w_n;
      COND_PL: w_cond_ex = ~w_n;
      COND_VS: w_cond_ex = w_v;
      COND_VC: w_cond_ex = ~w_v;
      COND_HI: w_cond_ex = w_c & ~w_z;
      COND_LS: w_cond_ex = ~(w_c & ~w_z);
      COND_GE: w_cond_ex = (w_n == w_v);
      COND_LT: w_cond_ex = (w_n != w_v);
      COND_GT: w_cond_ex = ~w_z & (w_n == w_v);
      COND_LE: w_cond_ex = w_z | (w_n != w_v);
      COND_AL: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;  // 4'hF never executes
    endcase
  end

  assign w_flag_write = FlagW & {w_cond_ex, w_cond_ex};

  assign PCSrc    = PCS  & w_cond_ex;
  assign RegWrite = RegW & w_cond_ex;
  assign MemWrite = MemW & w_cond_ex;

  // Flag register: N/Z and C/V halves update independently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else begin
      // NOTE: non-blocking so the new flags are only visible after the edge;
      // the instruction that sets them still sees the old values this cycle.
      if (w_flag_write[1]) r_flags[3:2] <= ALUFlags[3:2];
      if (w_flag_write[0]) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: rtl/controller.sv
// Control unit of the single-cycle ARM-subset processor: decodes
// Instr[31:12] into datapath controls; condition logic gates the writes.
module controller
  import arm_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [1:0]  ALUControl,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        PCSrc
);

  logic [3:0] w_cond;
  op_e        w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic       w_unused_rn;

  logic [1:0] w_reg_src;
  imm_src_e   w_imm_src;
  logic       w_alu_src;
  logic       w_reg_w;
  logic       w_mem_w;
  logic       w_mem_to_reg;
  logic       w_branch;
  logic       w_alu_op;
  alu_ctrl_e  w_alu_ctrl;
  logic [1:0] w_flag_w;
  logic       w_pcs;

  assign w_cond      = Instr[19:16];
  assign w_op        = op_e'(Instr[15:14]);
  assign w_funct     = Instr[13:8];
  assign w_rd        = Instr[3:0];
  // Rn is a datapath field; the controller never looks at it.
  assign w_unused_rn = ^Instr[7:4];

  // Main decode: instruction class selects the datapath configuration
  always_comb begin
    w_reg_src    = 2'b00;
    w_imm_src    = IMM_DP;
    w_alu_src    = 1'b0;
    w_reg_w      = 1'b0;
    w_mem_w      = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    w_alu_op     = 1'b0;
    case (w_op)
      OP_DP: begin
        w_alu_src = w_funct[5];  // I bit
        w_reg_w   = 1'b1;
        w_alu_op  = 1'b1;
      end
      OP_MEM: begin
        w_alu_src = 1'b1;
        w_imm_src = IMM_MEM;
        if (w_funct[0]) begin    // LDR
          w_reg_w      = 1'b1;
          w_mem_to_reg = 1'b1;
        end else begin           // STR reads Rd as store data
          w_mem_w   = 1'b1;
          w_reg_src = 2'b10;
        end
      end
      OP_BR: begin
        w_branch  = 1'b1;
        w_alu_src = 1'b1;
        w_imm_src = IMM_BR;
        w_reg_src = 2'b01;       // R15 as base
      end
      default: ;                 // undefined class: everything stays off
    endcase
  end

  // ALU decode: only data-processing instructions choose the ALU op and set flags
  always_comb begin
    w_alu_ctrl = ALU_ADD;
    w_flag_w   = 2'b00;
    if (w_alu_op) begin
      case (w_funct[4:1])
        CMD_ADD: w_alu_ctrl = ALU_ADD;
        CMD_SUB: w_alu_ctrl = ALU_SUB;
        CMD_AND: w_alu_ctrl = ALU_AND;
        CMD_ORR: w_alu_ctrl = ALU_ORR;
        default: w_alu_ctrl = ALU_ADD;
      endcase
      // Logical ops leave C and V untouched
      w_flag_w[1] = w_funct[0];
      w_flag_w[0] = w_funct[0] & ((w_alu_ctrl == ALU_ADD) | (w_alu_ctrl == ALU_SUB));
    end
  end

  // A write to R15 is a jump just like a branch
  assign w_pcs = ((w_rd == 4'hF) & w_reg_w) | w_branch;

  assign RegSrc     = w_reg_src;
  assign ImmSrc     = w_imm_src;
  assign ALUSrc     = w_alu_src;
  assign ALUControl = w_alu_ctrl;
  assign MemtoReg   = w_mem_to_reg;

  controller_condlogic u_condlogic (
    .clk      (clk),
    .reset    (reset),
    .Cond     (w_cond),
    .ALUFlags (ALUFlags),
    .FlagW    (w_flag_w),
    .PCS      (w_pcs),
    .RegW     (w_reg_w),
    .MemW     (w_mem_w),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite)
  );

endmodule

// File: tb/tb_controller.sv
// Bench for the ARM-subset controller: directed scenarios plus a random
// run checked against a behavioural model of decode and the flag register.
module tb_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [1:0]  ALUControl;
  logic        MemWrite;
  logic        MemtoReg;
  logic        PCSrc;

  int errors = 0;
  int checks = 0;
  logic [3:0] m_flags;  // model of the stored NZCV flags

  controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUSrc     (ALUSrc),
    .ALUControl (ALUControl),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .PCSrc      (PCSrc)
  );

  always #5 clk = ~clk;

  // Output bundle layout: {RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, MemtoReg, PCSrc}
  function automatic logic [10:0] dut_vec();
    return {RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemWrite, MemtoReg, PCSrc};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && n == v;
      4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_code(input logic [3:0] cmd);
    if (cmd == 4'b0010) return 2'b01;  // SUB
    if (cmd == 4'b0000) return 2'b10;  // AND
    if (cmd == 4'b1100) return 2'b11;  // ORR
    return 2'b00;                      // ADD and everything unsupported
  endfunction

  function automatic logic [10:0] model_out(input logic [19:0] ins, input logic [3:0] f);
    logic [1:0] op;
    logic [5:0] fn;
    logic dp, ld, st, br, ok, wr_reg, to_pc, src_b;
    logic [1:0] imm, alu;
    op = ins[15:14];
    fn = ins[13:8];
    ok = cond_holds(ins[19:16], f);
    dp = (op == 2'd0);
    ld = (op == 2'd1) && fn[0];
    st = (op == 2'd1) && !fn[0];
    br = (op == 2'd2);
    wr_reg = dp || ld;
    to_pc  = br || (wr_reg && ins[3:0] == 4'd15);
    src_b  = dp ? fn[5] : (ld || st || br);
    imm    = br ? 2'd2 : ((ld || st) ? 2'd1 : 2'd0);
    alu    = dp ? alu_code(fn[4:1]) : 2'b00;
    return {st, br, wr_reg && ok, imm, src_b, alu, st && ok, ld, to_pc && ok};
  endfunction

  function automatic logic [3:0] model_next(input logic [19:0] ins, input logic [3:0] alu_f,
                                            input logic [3:0] f);
    logic [3:0] nf;
    logic [3:0] cmd;
    nf  = f;
    cmd = ins[12:9];
    if (ins[15:14] == 2'd0 && ins[8] && cond_holds(ins[19:16], f)) begin
      nf[3:2] = alu_f[3:2];
      if (cmd != 4'b0000 && cmd != 4'b1100) nf[1:0] = alu_f[1:0];
    end
    return nf;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge: apply inputs, settle at the falling edge.
  task automatic drive(input logic [19:0] ins, input logic [3:0] af);
    Instr    = ins;
    ALUFlags = af;
    @(negedge clk);
  endtask

  // Cross a rising edge and let the model follow the flag register.
  task automatic tick();
    @(posedge clk);
    if (!reset) m_flags = 4'b0000;
    else        m_flags = model_next(Instr, ALUFlags, m_flags);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    m_flags = 4'b0000;
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [19:0] ins [4] = '{20'hE04F0, 20'h0A000, 20'h1A000, 20'h0A000};
    logic [10:0] exp [4] = '{11'b00_1_00_0_01_0_0_0, 11'b01_0_10_1_00_0_0_0,
                             11'b01_0_10_1_00_0_0_1, 11'b01_0_10_1_00_0_0_0};
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      // SUBS with Z set is presented before the last check: reset must win the edge
      drive(ins[i], 4'b0100);
      checks++;
      if (dut_vec() !== exp[i]) begin
        errors++;
        $display("FAIL reset_%0d instr=%h got=%b exp=%b", i, ins[i], dut_vec(), exp[i]);
      end
      if (i == 2) begin
        Instr = 20'hE0519;
        tick();
      end else begin
        tick();
      end
    end
    reset = 1'b1;
    m_flags = 4'b0000;
  endtask

  task automatic test_decode();
    logic [19:0] ins [7] = '{20'hE04F0, 20'hE2801, 20'hE5843, 20'hE5912,
                             20'hE1800, 20'hE0A00, 20'hE080F};
    logic [10:0] exp [7] = '{11'b00_1_00_0_01_0_0_0,   // SUB reg
                             11'b00_1_00_1_00_0_0_0,   // ADD imm
                             11'b10_0_01_1_00_1_0_0,   // STR
                             11'b00_1_01_1_00_0_1_0,   // LDR
                             11'b00_1_00_0_11_0_0_0,   // ORR
                             11'b00_1_00_0_00_0_0_0,   // unsupported cmd -> ADD
                             11'b00_1_00_0_00_0_0_1};  // ADD into R15
    for (int i = 0; i < 7; i++) begin
      drive(ins[i], 4'b0000);
      checks++;
      if (dut_vec() !== exp[i]) begin
        errors++;
        $display("FAIL decode_%0d instr=%h got=%b exp=%b", i, ins[i], dut_vec(), exp[i]);
      end
      tick();
    end
    // Op 11 and the never-execute condition
    drive(20'hEC000, 4'b0000);
    checks++;
    if (dut_vec() !== 11'b0) begin
      errors++;
      $display("FAIL decode_op11 got=%b exp=%b", dut_vec(), 11'b0);
    end
    drive(20'hF04F0, 4'b0000);
    checks++;
    if (dut_vec() !== 11'b00_0_00_0_01_0_0_0) begin
      errors++;
      $display("FAIL decode_nv got=%b exp=%b", dut_vec(), 11'b00_0_00_0_01_0_0_0);
    end
    tick();
  endtask

  task automatic test_branch_le();
    drive(20'hE0519, 4'b1000);  // SUBS: N=1, V=0
    tick();
    drive(20'hDA000, 4'b0000);
    checks++;
    if (dut_vec() !== 11'b01_0_10_1_00_0_0_1) begin
      errors++;
      $display("FAIL branch_le got=%b exp=%b", dut_vec(), 11'b01_0_10_1_00_0_0_1);
    end
    tick();
  endtask

  task automatic test_gt_lt();
    drive(20'hE0519, 4'b0010);  // SUBS: only C set
    tick();
    drive(20'hCA000, 4'b1111);
    checks++;
    if (PCSrc !== 1'b1) begin
      errors++;
      $display("FAIL branch_gt got=%b exp=1", PCSrc);
    end
    drive(20'hBA000, 4'b1111);
    checks++;
    if (PCSrc !== 1'b0) begin
      errors++;
      $display("FAIL branch_lt got=%b exp=0", PCSrc);
    end
    tick();
  endtask

  task automatic test_no_s_bit();
    // Flags are 0010 from the previous scenario; SUB without S must not touch them
    drive(20'hE0413, 4'b0100);
    tick();
    drive(20'h0A000, 4'b0000);
    checks++;
    if (PCSrc !== 1'b0) begin
      errors++;
      $display("FAIL nos_beq got=%b exp=0", PCSrc);
    end
    drive(20'h1A000, 4'b0000);
    checks++;
    if (PCSrc !== 1'b1) begin
      errors++;
      $display("FAIL nos_bne got=%b exp=1", PCSrc);
    end
    // ANDS updates N,Z but keeps C: flags become 0110 -> CS taken, EQ taken
    drive(20'hE0110, 4'b0101);
    tick();
    drive(20'h2A000, 4'b0000);
    checks++;
    if (PCSrc !== 1'b1) begin
      errors++;
      $display("FAIL ands_keeps_c got=%b exp=1", PCSrc);
    end
    tick();
  endtask

  task automatic test_gating();
    drive(20'hE0519, 4'b0100);  // SUBS: Z=1
    // Same-cycle evaluation still uses the old flags (C=1, Z=1 already? no: Z from ANDS)
    tick();
    drive(20'h10000, 4'b0000);  // ANDNE
    checks++;
    if (dut_vec() !== 11'b00_0_00_0_10_0_0_0) begin
      errors++;
      $display("FAIL gate_ne got=%b exp=%b", dut_vec(), 11'b00_0_00_0_10_0_0_0);
    end
    drive(20'h15843, 4'b0000);  // STRNE
    checks++;
    if (MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL gate_strne got=%b exp=0", MemWrite);
    end
    drive(20'hE5912, 4'b0000);  // LDR
    checks++;
    if (dut_vec() !== 11'b00_1_01_1_00_0_1_0) begin
      errors++;
      $display("FAIL gate_ldr got=%b exp=%b", dut_vec(), 11'b00_1_01_1_00_0_1_0);
    end
    drive(20'h0A000, 4'b0000);  // BEQ taken
    checks++;
    if (PCSrc !== 1'b1) begin
      errors++;
      $display("FAIL gate_beq got=%b exp=1", PCSrc);
    end
    #1 reset = 1'b0;            // asynchronous clear, away from any edge
    #1;
    checks++;
    if (PCSrc !== 1'b0) begin
      errors++;
      $display("FAIL gate_async_reset got=%b exp=0", PCSrc);
    end
    m_flags = 4'b0000;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [19:0] ins;
    logic [10:0] exp;
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      ins = 20'($urandom);
      if ($urandom_range(0, 3) == 0) ins[19:16] = 4'hE;
      if ($urandom_range(0, 2) == 0) ins[15:14] = 2'b00;  // favour flag-setting DP
      drive(ins, 4'($urandom));
      exp = model_out(ins, m_flags);
      checks++;
      if (dut_vec() !== exp) begin
        errors++;
        $display("FAIL random_%0d instr=%h flags=%b got=%b exp=%b",
                 i, ins, m_flags, dut_vec(), exp);
      end
      tick();
    end
  endtask

  initial begin
    reset    = 1'b0;
    Instr    = 20'h0;
    ALUFlags = 4'h0;
    m_flags  = 4'h0;
    test_reset();
    test_decode();
    test_branch_le();
    test_gt_lt();
    test_no_s_bit();
    test_gating();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
